// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving every ALUSystem control input.
// Control outputs are decoded combinationally from the current state and IROut.
module control_unit #(
    parameter logic [7:0]  PC_RESET = 8'h00,
    parameter int unsigned RSEL_W   = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       IROut,
    input  logic [3:0]        ALUOutFlag,
    output logic [1:0]        RF_OutASel,
    output logic [1:0]        RF_OutBSel,
    output logic [1:0]        RF_FunSel,
    output logic [1:0]        ARF_FunSel,
    output logic [1:0]        IR_Funsel,
    output logic [RSEL_W-1:0] RF_RSel,
    output logic [RSEL_W-1:0] RF_TSel,
    output logic [RSEL_W-1:0] ARF_RSel,
    output logic [3:0]        ALU_FunSel,
    output logic [1:0]        ARF_OutASel,
    output logic [1:0]        ARF_OutBSel,
    output logic              IR_LH,
    output logic              IR_Enable,
    output logic              Mem_WR,
    output logic              Mem_CS,
    output logic [1:0]        MuxASel,
    output logic [1:0]        MuxBSel,
    output logic              MuxCSel,
    output logic              Halted,
    output logic [2:0]        TState
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_EX0  = 3'd3,
        S_EX1  = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [3:0] OP_LDI = 4'd0;
    localparam logic [3:0] OP_LDM = 4'd1;
    localparam logic [3:0] OP_STM = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_BRA = 4'd7;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_HLT = 4'd9;

    localparam logic [1:0] FUN_CLR = 2'b00;
    localparam logic [1:0] FUN_LD  = 2'b01;
    localparam logic [1:0] FUN_INC = 2'b11;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;

    localparam logic [RSEL_W-1:0] SEL_NONE = '0;
    localparam logic [RSEL_W-1:0] SEL_ALL  = '1;
    localparam logic [RSEL_W-1:0] SEL_TOP  = {1'b1, {(RSEL_W-1){1'b0}}};
    localparam logic [RSEL_W-1:0] ARF_PC   = RSEL_W'(4'b1000);
    localparam logic [RSEL_W-1:0] ARF_AR   = RSEL_W'(4'b0100);
    localparam logic [RSEL_W-1:0] ARF_INIT = RSEL_W'(4'b1110);

    state_e state_q, state_d;

    logic [3:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [RSEL_W-1:0] rd_onehot;
    logic              unused_inputs;

    assign op        = IROut[15:12];
    assign rd        = IROut[11:10];
    assign rs        = IROut[9:8];
    // R1 sits in the top enable bit, so Rd=00 selects the MSB
    assign rd_onehot = SEL_TOP >> rd;

    // Immediate byte is routed by the datapath muxes; only Z gates a branch
    assign unused_inputs = ^{IROut[7:0], ALUOutFlag[2:0], PC_RESET};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = FUN_CLR;
        ARF_FunSel  = FUN_CLR;
        IR_Funsel   = FUN_CLR;
        RF_RSel     = SEL_NONE;
        RF_TSel     = SEL_NONE;
        ARF_RSel    = SEL_NONE;
        ALU_FunSel  = 4'b0000;
        ARF_OutASel = 2'b00;
        ARF_OutBSel = 2'b00;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = MUX_ALU;
        MuxBSel     = MUX_ALU;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;

        unique case (state_q)
            S_INIT: begin
                RF_RSel   = SEL_ALL;
                RF_TSel   = SEL_ALL;
                ARF_RSel  = ARF_INIT;
                IR_Enable = 1'b1;
                state_d   = S_F0;
            end
            S_F0, S_F1: begin
                // Read mem[PC] into one IR byte while PC increments
                ARF_OutBSel = 2'b00;
                Mem_CS      = 1'b0;
                IR_Enable   = 1'b1;
                IR_LH       = (state_q == S_F1);
                IR_Funsel   = FUN_LD;
                ARF_RSel    = ARF_PC;
                ARF_FunSel  = FUN_INC;
                state_d     = (state_q == S_F0) ? S_F1 : S_EX0;
            end
            S_EX0: begin
                state_d = S_F0;
                case (op)
                    OP_LDI: begin
                        MuxASel   = MUX_IMM;
                        RF_RSel   = rd_onehot;
                        RF_FunSel = FUN_LD;
                    end
                    OP_LDM, OP_STM: begin
                        MuxBSel    = MUX_IMM;
                        ARF_RSel   = ARF_AR;
                        ARF_FunSel = FUN_LD;
                        state_d    = S_EX1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        RF_OutASel = rd;
                        RF_OutBSel = rs;
                        MuxCSel    = 1'b1;
                        MuxASel    = MUX_ALU;
                        RF_RSel    = rd_onehot;
                        RF_FunSel  = FUN_LD;
                        case (op)
                            OP_ADD:  ALU_FunSel = 4'b0100;
                            OP_SUB:  ALU_FunSel = 4'b0110;
                            OP_AND:  ALU_FunSel = 4'b0111;
                            default: ALU_FunSel = 4'b1000;
                        endcase
                    end
                    OP_BRA, OP_BEQ: begin
                        if (op == OP_BRA || ALUOutFlag[3]) begin
                            MuxBSel    = MUX_IMM;
                            ARF_RSel   = ARF_PC;
                            ARF_FunSel = FUN_LD;
                        end
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                    end
                endcase
            end
            S_EX1: begin
                state_d = S_F0;
                if (op == OP_LDM) begin
                    ARF_OutBSel = 2'b01;
                    Mem_CS      = 1'b0;
                    MuxASel     = MUX_MEM;
                    RF_RSel     = rd_onehot;
                    RF_FunSel   = FUN_LD;
                end else if (op == OP_STM) begin
                    // ALU passes Rd through to memory data at address AR
                    ARF_OutBSel = 2'b01;
                    RF_OutASel  = rd;
                    MuxCSel     = 1'b1;
                    ALU_FunSel  = 4'b0000;
                    Mem_CS      = 1'b0;
                    Mem_WR      = 1'b1;
                end
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign TState = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected control words are queued per
// instruction and compared against the DUT outputs on each falling edge.
module tb_control_unit;

    typedef struct packed {
        logic [1:0] rf_outa;
        logic [1:0] rf_outb;
        logic [1:0] rf_fun;
        logic [1:0] arf_fun;
        logic [1:0] ir_fun;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] arf_rsel;
        logic [3:0] alu_fun;
        logic [1:0] arf_outa;
        logic [1:0] arf_outb;
        logic       ir_lh;
        logic       ir_en;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic       halted;
        logic [2:0] tstate;
    } word_t;

    typedef struct {
        string tag;
        word_t w;
    } sb_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, IR_Funsel;
    logic [3:0]  RF_RSel, RF_TSel, ARF_RSel, ALU_FunSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, MuxASel, MuxBSel;
    logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;
    logic [2:0]  TState;

    word_t obs;
    word_t w;
    word_t w1;
    sb_t   sb_q[$];
    int    n_total = 0;
    int    n_bad   = 0;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .ARF_FunSel(ARF_FunSel), .IR_Funsel(IR_Funsel), .RF_RSel(RF_RSel),
        .RF_TSel(RF_TSel), .ARF_RSel(ARF_RSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .IR_LH(IR_LH),
        .IR_Enable(IR_Enable), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted), .TState(TState)
    );

    always_comb begin
        obs = '{RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, IR_Funsel,
                RF_RSel, RF_TSel, ARF_RSel, ALU_FunSel, ARF_OutASel, ARF_OutBSel,
                IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel,
                Halted, TState};
    end

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic word_t idle_w(input logic [2:0] ts);
        word_t r;
        r        = '0;
        r.mem_cs = 1'b1;
        r.tstate = ts;
        return r;
    endfunction

    function automatic word_t init_w();
        word_t r;
        r          = idle_w(3'd0);
        r.rf_rsel  = 4'b1111;
        r.rf_tsel  = 4'b1111;
        r.arf_rsel = 4'b1110;
        r.ir_en    = 1'b1;
        return r;
    endfunction

    function automatic word_t fetch_w(input logic hi);
        word_t r;
        r          = idle_w(hi ? 3'd2 : 3'd1);
        r.mem_cs   = 1'b0;
        r.ir_en    = 1'b1;
        r.ir_lh    = hi;
        r.ir_fun   = 2'b01;
        r.arf_rsel = 4'b1000;
        r.arf_fun  = 2'b11;
        return r;
    endfunction

    task automatic push(input string tag, input word_t x);
        sb_t e;
        e.tag = tag;
        e.w   = x;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        sb_t e;
        @(negedge Clock);
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_empty: got=empty exp=entry");
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.w);
        end
    endtask

    task automatic drain();
        int n;
        n = sb_q.size();
        repeat (n) pop_check();
    endtask

    task automatic run_instr(input string name, input logic [15:0] ir,
                             input logic [3:0] fl, input word_t ex0,
                             input bit has_ex1, input word_t ex1);
        @(posedge Clock);
        #1;
        IROut      = ir;
        ALUOutFlag = fl;
        push({name, ".f0"}, fetch_w(1'b0));
        push({name, ".f1"}, fetch_w(1'b1));
        push({name, ".ex0"}, ex0);
        if (has_ex1) push({name, ".ex1"}, ex1);
        drain();
    endtask

    initial begin
        Reset      = 1'b0;
        IROut      = 16'h0000;
        ALUOutFlag = 4'b0000;

        repeat (3) begin
            push("rst_low", init_w());
            pop_check();
        end
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        push("init", init_w());
        drain();

        w = idle_w(3'd3); w.mux_a = 2'b10; w.rf_rsel = 4'b0001; w.rf_fun = 2'b01;
        run_instr("ldi", 16'h0C2A, 4'b0000, w, 1'b0, w);

        w = idle_w(3'd3); w.mux_b = 2'b10; w.arf_rsel = 4'b0100; w.arf_fun = 2'b01;
        w1 = idle_w(3'd4); w1.arf_outb = 2'b01; w1.mem_cs = 1'b0; w1.mux_a = 2'b01;
        w1.rf_rsel = 4'b0100; w1.rf_fun = 2'b01;
        run_instr("ldm", 16'h1455, 4'b0000, w, 1'b1, w1);

        w1 = idle_w(3'd4); w1.arf_outb = 2'b01; w1.rf_outa = 2'b11; w1.mux_c = 1'b1;
        w1.mem_cs = 1'b0; w1.mem_wr = 1'b1;
        run_instr("stm", 16'h2C33, 4'b0000, w, 1'b1, w1);

        w = idle_w(3'd3); w.rf_outa = 2'b10; w.rf_outb = 2'b01; w.mux_c = 1'b1;
        w.rf_rsel = 4'b0010; w.rf_fun = 2'b01; w.alu_fun = 4'b0110;
        run_instr("sub", 16'h4900, 4'b0000, w, 1'b0, w);

        w = idle_w(3'd3); w.rf_outa = 2'b00; w.rf_outb = 2'b01; w.mux_c = 1'b1;
        w.rf_rsel = 4'b1000; w.rf_fun = 2'b01; w.alu_fun = 4'b0100;
        run_instr("add", 16'h3100, 4'b0000, w, 1'b0, w);

        w = idle_w(3'd3); w.rf_outa = 2'b11; w.rf_outb = 2'b10; w.mux_c = 1'b1;
        w.rf_rsel = 4'b0001; w.rf_fun = 2'b01; w.alu_fun = 4'b0111;
        run_instr("and", 16'h5E00, 4'b0000, w, 1'b0, w);

        w = idle_w(3'd3); w.rf_outa = 2'b01; w.rf_outb = 2'b11; w.mux_c = 1'b1;
        w.rf_rsel = 4'b0100; w.rf_fun = 2'b01; w.alu_fun = 4'b1000;
        run_instr("or", 16'h6700, 4'b0000, w, 1'b0, w);

        w = idle_w(3'd3); w.mux_b = 2'b10; w.arf_rsel = 4'b1000; w.arf_fun = 2'b01;
        run_instr("bra", 16'h7010, 4'b0000, w, 1'b0, w);
        run_instr("beq_taken", 16'h8010, 4'b1000, w, 1'b0, w);

        w = idle_w(3'd3);
        run_instr("beq_not", 16'h8010, 4'b0000, w, 1'b0, w);
        run_instr("beq_cno", 16'h8010, 4'b0111, w, 1'b0, w);
        run_instr("nop_a", 16'hA000, 4'b0000, w, 1'b0, w);
        run_instr("nop_f", 16'hF123, 4'b1111, w, 1'b0, w);

        run_instr("hlt", 16'h9000, 4'b0000, w, 1'b0, w);
        w = idle_w(3'd5); w.halted = 1'b1;
        repeat (10) push("halt", w);
        drain();

        @(posedge Clock);
        #1;
        Reset = 1'b0;
        push("halt_rst", init_w());
        drain();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        push("rst_init", init_w());
        drain();

        w = idle_w(3'd3);
        run_instr("post_rst", 16'hA000, 4'b0000, w, 1'b0, w);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired sequencer that drives every control input of ALUSystem, replacing the externally supplied test-vector control word.
- Consumes IROut and ALUOutFlag from the datapath.
- Runs a fetch (two memory bytes into IR) / decode / execute cycle.
- Sits beside ALUSystem at the top of the CPU; all datapath activity is slaved to its outputs.

Parameters:
- PC_RESET, 8'h00, value PC holds after INIT (applied by clear, so only 8'h00 is supported).
- RSEL_W, 4, width of the one-hot RF_RSel, RF_TSel and ARF_RSel fields.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IROut  in  16  instruction register contents.
- ALUOutFlag  in  4  {Z,C,N,O}, Z = bit 3.
- RF_OutASel, RF_OutBSel  out  2 each  register file read selects (00=R1 .. 11=R4).
- RF_FunSel, ARF_FunSel, IR_Funsel  out  2 each  00 clear, 01 load, 10 decrement, 11 increment.
- RF_RSel, RF_TSel, ARF_RSel  out  4 each  one-hot enables; RF bit3=R1..bit0=R4; ARF bit3=PC, bit2=AR, bit1=SP.
- ALU_FunSel  out  4  ALU operation select.
- ARF_OutASel, ARF_OutBSel  out  2 each  ARF output selects; 00=PC, 01=AR, 10=SP.
- IR_LH  out  1  0 = load IR low byte, 1 = load IR high byte.
- IR_Enable  out  1  IR write enable.
- Mem_WR  out  1  1 = write, 0 = read.
- Mem_CS  out  1  active-low chip select.
- MuxASel, MuxBSel  out  2 each  00 ALUOut, 01 MemoryOut, 10 IROut[7:0], 11 ARF_AOut.
- MuxCSel  out  1  0 = ARF_AOut, 1 = RF AOut.
- Halted  out  1  high in HALT.
- TState  out  3  current state encoding, for debug.

Behaviour:
- State register: INIT=0, F0=1, F1=2, EX0=3, EX1=4, HALT=5. Outputs are decoded combinationally from the state and IROut.
- Idle word: every RSel and TSel = 0, IR_Enable=0, Mem_CS=1, Mem_WR=0, all other fields 0. This is the idle word referred to below.
- Reset low (asynchronous): state ← INIT and outputs = INIT word, also asserted mid-instruction.
- INIT (one cycle after Reset rises):
  - clear everything: RF_RSel = RF_TSel = 1111, ARF_RSel = 1110, IR_Enable = 1, all FunSels = 00.
  - next state F0.
- F0: ARF_OutBSel=00, Mem_CS=0, Mem_WR=0, IR_Enable=1, IR_LH=0, IR_Funsel=01, ARF_RSel=1000, ARF_FunSel=11 (PC++). Next state F1.
- F1: same as F0 with IR_LH=1. Next state EX0.
- Decode: op = IROut[15:12], Rd = IROut[11:10], Rs = IROut[9:8], K = IROut[7:0].
- EX0 by op (next state F0 unless noted):
  - 0 LDI: MuxASel=10, RF_RSel=onehot(Rd), RF_FunSel=01.
  - 1 LDM / 2 STM: MuxBSel=10, ARF_RSel=0100, ARF_FunSel=01 (AR←K); next state EX1.
  - 3 ADD / 4 SUB / 5 AND / 6 OR:
    - RF_OutASel=Rd, RF_OutBSel=Rs, MuxCSel=1, MuxASel=00, RF_RSel=onehot(Rd), RF_FunSel=01.
    - ALU_FunSel: ADD=0100, SUB=0110, AND=0111, OR=1000.
  - 7 BRA: MuxBSel=10, ARF_RSel=1000, ARF_FunSel=01 (PC←K).
  - 8 BEQ: same as BRA only if ALUOutFlag[3]=1 at that edge; otherwise the idle word.
  - 9 HLT: idle word; next state HALT.
  - 10–15: idle word (NOP).
- EX1 (next state F0):
  - LDM: ARF_OutBSel=01, Mem_CS=0, Mem_WR=0, MuxASel=01, RF_RSel=onehot(Rd), RF_FunSel=01.
  - STM: ARF_OutBSel=01, RF_OutASel=Rd, MuxCSel=1, ALU_FunSel=0000 (pass A), Mem_CS=0, Mem_WR=1.
- HALT: idle word, Halted=1; stays in HALT until Reset.
- Latency per instruction:
  - 3 cycles: LDI, ALU ops, branches, NOP.
  - 4 cycles: LDM, STM.
  - INIT is a single cycle after reset.
- Mem_WR=1 is permitted only in the STM EX1 state; no state asserts Mem_CS=0 together with IR_Enable=0 and Mem_WR=0 outside LDM EX1.

Test Plan:
- Reset low for 3 cycles, then release → outputs hold the INIT word while low; TState=0 for one cycle, then 1; the following cycle drives Mem_CS=0, IR_LH=0, PC increment.
- IROut=16'h0C2A (LDI R4,0x2A) held through EX0 → RF_RSel=0001, MuxASel=10, RF_FunSel=01; TState sequence 1,2,3,1.
- IROut=16'h1455 (LDM R2,0x55) → EX0: ARF_RSel=0100, MuxBSel=10; EX1: Mem_CS=0, Mem_WR=0, ARF_OutBSel=01, RF_RSel=0100, MuxASel=01.
- IROut=16'h4900 (SUB R3,R2) → ALU_FunSel=0110, RF_OutASel=10, RF_OutBSel=01, RF_RSel=0010, MuxCSel=1.
- IROut=16'h8010 with ALUOutFlag=4'b0000, then with 4'b1000 → first: ARF_RSel=0000; second: ARF_RSel=1000, ARF_FunSel=01, MuxBSel=10.
- IROut=16'h9000 (HLT), then Reset pulse during HALT → Halted=1 and the idle word persist for 10 cycles; the Reset pulse returns the unit to INIT.
